bj_hand_ctrl: RTL and testbench

//  Player-hand controller for the blackjack design, directly downstream of the

---
 rtl/bj_pkg.sv | 27 ++
 rtl/bj_edge_det.sv | 18 +
 rtl/bj_hand_ctrl.sv | 132 +++++++++++++
 tb/tb_bj_hand_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bj_pkg.sv
// Shared blackjack definitions: hand FSM states, card/score widths and card sanitising.
// Used by the hand controller and by the judge/display blocks.
package bj_pkg;

    localparam int CARD_W  = 4;
    localparam int SCORE_W = 5;
    localparam int ACE_VAL = 11;
    localparam int ACE_ADJ = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEAL,
        S_WAIT,
        S_ADD,
        S_EVAL,
        S_HOLD,
        S_BUSTED
    } state_t;

    // Generator codes outside 1..11 are scored as a ten-value card
    function automatic logic [CARD_W-1:0] card_sanitize(input logic [CARD_W-1:0] c);
        if (c == '0 || c > CARD_W'(ACE_VAL))
            return CARD_W'(10);
        return c;
    endfunction

endpackage

// File: rtl/bj_edge_det.sv
// Single-bit rising-edge detector with asynchronous active-high reset.
module bj_edge_det (
    input  logic CLK,
    input  logic RES,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) d_q <= 1'b0;
        else     d_q <= d;
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/bj_hand_ctrl.sv
// Player-hand controller: deals two cards, takes hits on DRAW edges, keeps a
// soft-ace corrected score and reports bust / natural / hand-complete status.
module bj_hand_ctrl
    import bj_pkg::*;
#(
    parameter int LIMIT     = 21,
    parameter int MAX_CARDS = 8
) (
    input  logic               CLK,
    input  logic               RES,
    input  logic [CARD_W-1:0]  CARD,
    output logic               ENC,
    input  logic               NEWG,
    input  logic               DRAW,
    input  logic               STAND,
    output logic [SCORE_W-1:0] SCORE,
    output logic [3:0]         NCARD,
    output logic               SOFT,
    output logic               BUSY,
    output logic               BUST,
    output logic               BJACK,
    output logic               DONE
);

    localparam logic [SCORE_W-1:0] LIM  = SCORE_W'(LIMIT);
    localparam logic [3:0]         MAXC = 4'(MAX_CARDS);

    state_t              state, state_nxt;
    logic                draw_rise, stand_rise;
    logic [CARD_W-1:0]   card_r;
    logic [3:0]          aces;
    logic [1:0]          deal_cnt;
    logic [SCORE_W-1:0]  score;
    logic [3:0]          ncard;
    logic                soft_r, bjack_r, enc_r;

    bj_edge_det u_draw_edge  (.CLK(CLK), .RES(RES), .d(DRAW),  .rise(draw_rise));
    bj_edge_det u_stand_edge (.CLK(CLK), .RES(RES), .d(STAND), .rise(stand_rise));

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (NEWG) begin
            state_nxt = S_DEAL;
        end else begin
            case (state)
                S_DEAL: state_nxt = S_ADD;
                S_WAIT: begin
                    // STAND takes priority over a simultaneous DRAW
                    if (stand_rise)     state_nxt = S_HOLD;
                    else if (draw_rise) state_nxt = S_ADD;
                end
                S_ADD:  state_nxt = S_EVAL;
                S_EVAL: begin
                    if (score > LIM && aces != '0)          state_nxt = S_EVAL;
                    else if (score > LIM)                   state_nxt = S_BUSTED;
                    else if (deal_cnt != '0)                state_nxt = S_DEAL;
                    else if (score == LIM || ncard == MAXC) state_nxt = S_HOLD;
                    else                                    state_nxt = S_WAIT;
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            enc_r    <= 1'b0;
            card_r   <= '0;
            aces     <= '0;
            deal_cnt <= '0;
            score    <= '0;
            ncard    <= '0;
            soft_r   <= 1'b0;
            bjack_r  <= 1'b0;
        end else begin
            enc_r <= 1'b1;
            if (NEWG) begin
                aces     <= '0;
                deal_cnt <= 2'd2;
                score    <= '0;
                ncard    <= '0;
                soft_r   <= 1'b0;
                bjack_r  <= 1'b0;
            end else begin
                case (state)
                    S_DEAL: begin
                        card_r   <= card_sanitize(CARD);
                        deal_cnt <= deal_cnt - 2'd1;
                    end
                    S_WAIT: begin
                        if (draw_rise && !stand_rise)
                            card_r <= card_sanitize(CARD);
                    end
                    S_ADD: begin
                        score <= score + SCORE_W'(card_r);
                        ncard <= ncard + 4'd1;
                        if (card_r == CARD_W'(ACE_VAL)) begin
                            aces   <= aces + 4'd1;
                            soft_r <= 1'b1;
                        end
                    end
                    S_EVAL: begin
                        // Demote one ace from 11 to 1 per cycle while over the limit
                        if (score > LIM && aces != '0) begin
                            score  <= score - SCORE_W'(ACE_ADJ);
                            aces   <= aces - 4'd1;
                            soft_r <= (aces != 4'd1);
                        end
                        if (score == LIM && ncard == 4'd2)
                            bjack_r <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign ENC   = enc_r;
    assign SCORE = score;
    assign NCARD = ncard;
    assign SOFT  = soft_r;
    assign BJACK = bjack_r;
    assign BUSY  = (state == S_DEAL) || (state == S_ADD) || (state == S_EVAL);
    assign BUST  = (state == S_BUSTED);
    assign DONE  = (state == S_HOLD) || (state == S_BUSTED);

endmodule

// File: tb/tb_bj_hand_ctrl.sv
// Directed bench for bj_hand_ctrl: a blackjack hand model checked whenever the
// controller is idle, plus literal expectations for each scenario.
module tb_bj_hand_ctrl;

    localparam int LIM  = 21;
    localparam int MAXC = 8;

    logic       CLK = 1'b0;
    logic       RES = 1'b1;
    logic [3:0] CARD = 4'd0;
    logic       ENC;
    logic       NEWG = 1'b0, DRAW = 1'b0, STAND = 1'b0;
    logic [4:0] SCORE;
    logic [3:0] NCARD;
    logic       SOFT, BUSY, BUST, BJACK, DONE;

    bj_hand_ctrl #(.LIMIT(LIM), .MAX_CARDS(MAXC)) dut (
        .CLK(CLK), .RES(RES), .CARD(CARD), .ENC(ENC), .NEWG(NEWG),
        .DRAW(DRAW), .STAND(STAND), .SCORE(SCORE), .NCARD(NCARD),
        .SOFT(SOFT), .BUSY(BUSY), .BUST(BUST), .BJACK(BJACK), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Hand model: the cards actually taken, and whether the player stood
    int mcards[$];
    bit mstood = 1'b0;

    function automatic int card_val(int c);
        return (c < 1 || c > 11) ? 10 : c;
    endfunction

    function automatic int m_score();
        int s = 0, a = 0;
        foreach (mcards[i]) begin
            s += mcards[i];
            if (mcards[i] == 11) a++;
        end
        while (s > LIM && a > 0) begin s -= 10; a--; end
        return s;
    endfunction

    function automatic int m_soft();
        int s = 0, a = 0;
        foreach (mcards[i]) begin
            s += mcards[i];
            if (mcards[i] == 11) a++;
        end
        while (s > LIM && a > 0) begin s -= 10; a--; end
        return (a > 0) ? 1 : 0;
    endfunction

    function automatic bit m_done();
        int s = m_score();
        return (s > LIM) || mstood || (s == LIM) || (mcards.size() == MAXC);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en && !RES && !BUSY) begin
            chk("m_score", int'(SCORE), m_score());
            chk("m_ncard", int'(NCARD), mcards.size());
            chk("m_soft",  int'(SOFT),  m_soft());
            chk("m_bust",  int'(BUST),  (m_score() > LIM) ? 1 : 0);
            chk("m_bjack", int'(BJACK), (mcards.size() == 2 && m_score() == LIM) ? 1 : 0);
            chk("m_done",  int'(DONE),  m_done() ? 1 : 0);
            chk("m_enc",   int'(ENC),   1);
        end
    end

    task automatic settle();
        int k;
        for (k = 0; k < 50; k++) begin
            @(negedge CLK);
            if (!BUSY) break;
        end
        if (k == 50) begin
            n_chk++;
            n_fail++;
            $display("FAIL settle_timeout: BUSY still %0d, expected 0", BUSY);
        end
        chk_en = 1'b1;
    endtask

    task automatic new_game(input int c1, input int c2);
        @(posedge CLK); #1;
        chk_en = 1'b0;
        NEWG = 1'b1; CARD = 4'(c1);
        mcards.delete(); mstood = 1'b0;
        @(posedge CLK); #1;
        NEWG = 1'b0;
        @(posedge CLK); #1;
        CARD = 4'(c2);
        mcards.push_back(card_val(c1));
        mcards.push_back(card_val(c2));
        settle();
    endtask

    task automatic draw(input int c);
        @(posedge CLK); #1;
        chk_en = 1'b0;
        DRAW = 1'b1; CARD = 4'(c);
        if (!m_done()) mcards.push_back(card_val(c));
        @(posedge CLK); #1;
        DRAW = 1'b0;
        settle();
    endtask

    task automatic stand(input bit with_draw, input int c);
        @(posedge CLK); #1;
        chk_en = 1'b0;
        STAND = 1'b1; DRAW = with_draw; CARD = 4'(c);
        if (!m_done()) mstood = 1'b1;
        @(posedge CLK); #1;
        STAND = 1'b0; DRAW = 1'b0;
        settle();
    endtask

    initial begin
        // 1: reset values and ENC release
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_score", int'(SCORE), 0);
        chk("rst_ncard", int'(NCARD), 0);
        chk("rst_enc",   int'(ENC),   0);
        chk("rst_flags", int'({SOFT, BUSY, BUST, BJACK, DONE}), 0);
        RES = 1'b0;
        @(posedge CLK); #1;
        chk("enc_after_release", int'(ENC), 1);
        chk_en = 1'b1;
        repeat (2) @(negedge CLK);

        // 2: natural 10 + ace
        new_game(10, 11);
        chk("t2_score", int'(SCORE), 21);
        chk("t2_ncard", int'(NCARD), 2);
        chk("t2_bjack", int'(BJACK), 1);
        chk("t2_soft",  int'(SOFT),  1);
        chk("t2_done",  int'(DONE),  1);
        chk("t2_bust",  int'(BUST),  0);

        // 3: 10,6 then 9 busts; score visible one edge after the DRAW edge
        new_game(10, 6);
        chk("t3_score16", int'(SCORE), 16);
        chk("t3_wait_done", int'(DONE), 0);
        @(posedge CLK); #1;
        chk_en = 1'b0;
        DRAW = 1'b1; CARD = 4'd9;
        mcards.push_back(9);
        @(posedge CLK); #1;
        DRAW = 1'b0;
        @(posedge CLK); #1;
        chk("t3_latency_score", int'(SCORE), 25);
        settle();
        chk("t3_score", int'(SCORE), 25);
        chk("t3_bust",  int'(BUST),  1);
        chk("t3_done",  int'(DONE),  1);
        chk("t3_ncard", int'(NCARD), 3);

        // 4: soft-ace corrections
        new_game(11, 11);
        chk("t4_score_a", int'(SCORE), 12);
        chk("t4_soft_a",  int'(SOFT),  1);
        draw(11);
        chk("t4_score_b", int'(SCORE), 13);
        chk("t4_soft_b",  int'(SOFT),  1);
        draw(10);
        chk("t4_score_c", int'(SCORE), 13);
        chk("t4_soft_c",  int'(SOFT),  0);
        chk("t4_bust_c",  int'(BUST),  0);

        // 5: DRAW and STAND together: stand wins, then later draws ignored
        new_game(9, 6);
        stand(1'b1, 5);
        chk("t5_done",  int'(DONE),  1);
        chk("t5_score", int'(SCORE), 15);
        chk("t5_ncard", int'(NCARD), 2);
        draw(4);
        chk("t5_ignored_score", int'(SCORE), 15);

        // Out-of-range generator codes count as ten
        new_game(0, 12);
        chk("bad_card_score", int'(SCORE), 20);
        chk("bad_card_done",  int'(DONE),  0);

        // 6a: eight twos reach the card limit
        new_game(2, 2);
        for (int i = 0; i < 6; i++) draw(2);
        chk("t6a_score", int'(SCORE), 16);
        chk("t6a_ncard", int'(NCARD), 8);
        chk("t6a_done",  int'(DONE),  1);
        chk("t6a_bust",  int'(BUST),  0);

        // 6b: reset asserted while evaluating a hit
        new_game(10, 2);
        @(posedge CLK); #1;
        chk_en = 1'b0;
        DRAW = 1'b1; CARD = 4'd3;
        @(posedge CLK); #1;
        DRAW = 1'b0;
        @(posedge CLK); #1;
        chk("t6b_busy_before", int'(BUSY), 1);
        RES = 1'b1;
        #1;
        chk("t6b_score", int'(SCORE), 0);
        chk("t6b_ncard", int'(NCARD), 0);
        chk("t6b_enc",   int'(ENC),   0);
        chk("t6b_flags", int'({SOFT, BUSY, BUST, BJACK, DONE}), 0);
        mcards.delete(); mstood = 1'b0;
        @(posedge CLK); #1;
        RES = 1'b0;
        @(posedge CLK); #1;
        chk("t6b_enc_back", int'(ENC), 1);
        chk_en = 1'b1;
        repeat (3) @(negedge CLK);

        // Fresh game after reset behaves normally
        new_game(5, 4);
        draw(11);
        chk("post_score", int'(SCORE), 20);
        chk("post_soft",  int'(SOFT),  1);

        #1;
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
